sram_requester: RTL and testbench

- Client-side initiator for the SRAM controller's request interface (read/write/inp_addr/inp_data in; workdone/out_data out).
- Accepts commands from a consumer (e.g. sample fetch or score loader) into a small FIFO.
- Issues each command as a held read/write level, detects completion from the level-style workdone, returns read data on a response port with backpressure.
- Includes a per-transaction watchdog timeout.

---
 rtl/sram_pkg.sv | 30 +++
 rtl/sram_cmd_fifo.sv | 59 +++++
 rtl/sram_requester.sv | 186 ++++++++++++++++++
 tb/tb_sram_requester.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
//==============================================================================
// Module      : sram_pkg
// Description : Shared widths, requester FSM encoding and command bundle
//               for the SRAM request path.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package sram_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAP  = 2'd3
   } req_state_e;

   typedef struct packed {
      logic                   we;
      logic [SRAM_ADDR_W-1:0] addr;
      logic [SRAM_DATA_W-1:0] wdata;
   } sram_cmd_t;

endpackage

`default_nettype wire

// File: rtl/sram_cmd_fifo.sv
//==============================================================================
// Module      : sram_cmd_fifo
// Description : Circular command FIFO, wrap-bit pointers, head visible on dout.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 53
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   // full is judged before any same-cycle pop, so a pop never makes room early
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
            wr_ptr_q                   <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sram_requester.sv
//==============================================================================
// Module      : sram_requester
// Description : Queues consumer commands and issues them to the SRAM
//               controller as held levels, with watchdog and read response.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_requester
   import sram_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64,
   parameter int ADDR_W     = SRAM_ADDR_W,
   parameter int DATA_W     = SRAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   cmd_t             cmd_in;
   cmd_t             head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   req_state_e       state_q,       state_d;
   logic             mem_read_q,    mem_read_d;
   logic             mem_write_q,   mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic             timeout_err_q, timeout_err_d;
   logic             rsp_valid_q,   rsp_valid_d;
   logic [ADDR_W-1:0] rsp_addr_q,   rsp_addr_d;
   logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;

   assign cmd_in = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};

   sram_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(cmd_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cmd_valid),
      .data_i  (cmd_in),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;
      rsp_valid_d   = rsp_valid_q & ~rsp_ready;
      rsp_addr_d    = rsp_addr_q;
      rsp_data_d    = rsp_data_q;
      pop           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // reads wait for the response slot to drain; writes never need it
            if (!fifo_empty && (head.we || !rsp_valid_q)) begin
               pop         = 1'b1;
               mem_addr_d  = head.addr;
               mem_wdata_d = head.wdata;
               mem_write_d = head.we;
               mem_read_d  = ~head.we;
               cnt_d       = '0;
               state_d     = ST_ARM;
            end
         end
         ST_ARM: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               timeout_err_d = 1'b1;
               mem_read_d    = 1'b0;
               mem_write_d   = 1'b0;
               state_d       = ST_GAP;
            end else if (!mem_done) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_done) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (mem_read_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_addr_d  = mem_addr_q;
                  rsp_data_d  = mem_rdata;
               end
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  timeout_err_d = 1'b1;
                  mem_read_d    = 1'b0;
                  mem_write_d   = 1'b0;
                  state_d       = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_addr_q    <= '0;
         rsp_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_addr_q    <= rsp_addr_d;
         rsp_data_q    <= rsp_data_d;
      end
   end

   assign cmd_ready   = ~fifo_full;
   assign busy        = (state_q != ST_IDLE) | ~fifo_empty;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign timeout_err = timeout_err_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_addr    = rsp_addr_q;
   assign rsp_data    = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_requester.sv
//==============================================================================
// Module      : tb_sram_requester
// Description : Requester against a level-done controller/SRAM model with a
//               response scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_requester;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_we = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_data;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              timeout_err;

   always #5 clk = ~clk;

   sram_requester #(
      .FIFO_DEPTH (4),
      .TIMEOUT    (64),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_we      (cmd_we),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_addr    (rsp_addr),
      .rsp_data    (rsp_data),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_done    (mem_done),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // Controller + SRAM model: done is a level that drops when a request is
   // taken and rises on completion; read latency 5, write 6 working cycles.
   logic [DATA_W-1:0] sram [logic [ADDR_W-1:0]];
   int  ctl_phase = 0;
   int  ctl_cnt   = 0;
   int  stale_cfg = 0;
   bit  hang      = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_done  <= 1'b0;
         mem_rdata <= '0;
         ctl_phase <= 0;
         ctl_cnt   <= 0;
      end else begin
         case (ctl_phase)
            0: if (mem_read || mem_write) begin
               if (stale_cfg == 0) begin
                  mem_done  <= 1'b0;
                  ctl_cnt   <= mem_write ? 6 : 5;
                  ctl_phase <= 1;
               end else begin
                  ctl_cnt   <= stale_cfg - 1;
                  ctl_phase <= 3;
               end
            end
            3: if (ctl_cnt == 0) begin
               mem_done  <= 1'b0;
               ctl_cnt   <= mem_write ? 6 : 5;
               ctl_phase <= 1;
            end else begin
               ctl_cnt <= ctl_cnt - 1;
            end
            1: if (!(mem_read || mem_write)) begin
               ctl_phase <= 0;
            end else if (ctl_cnt == 0) begin
               if (!hang) begin
                  if (mem_write) sram[mem_addr] = mem_wdata;
                  else mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : '0;
                  mem_done  <= 1'b1;
                  ctl_phase <= 2;
               end
            end else begin
               ctl_cnt <= ctl_cnt - 1;
            end
            default: if (!(mem_read || mem_write)) ctl_phase <= 0;
         endcase
      end
   end

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } exp_t;

   exp_t              exp_q [$];
   exp_t              e_pop;
   logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Negedge monitor: request/idle run lengths, response checks, timeout timing
   int cyc = 0, req_run = 0, lo_run = 0, rsp_run = 0;
   int last_req = 0, last_lo = 0, last_rsp = 0, t_req_rise = 0, to_delay = -1;
   bit both_seen = 1'b0, to_seen = 1'b0, to_drop = 1'b1;

   always @(negedge clk) begin
      if (!rst) begin
         req_run = 0; lo_run = 0; rsp_run = 0; last_req = 0; last_lo = 0; last_rsp = 0;
      end else begin
         if (mem_read && mem_write) both_seen = 1'b1;
         if (mem_read || mem_write) begin
            if (req_run == 0) t_req_rise = cyc;
            if (lo_run > 0) last_lo = lo_run;
            lo_run = 0;
            req_run++;
         end else begin
            if (req_run > 0) last_req = req_run;
            req_run = 0;
            lo_run++;
         end
         if (rsp_valid) rsp_run++;
         else begin
            if (rsp_run > 0) last_rsp = rsp_run;
            rsp_run = 0;
         end
         if (timeout_err && !to_seen) begin
            to_seen  = 1'b1;
            to_delay = cyc - t_req_rise;
            to_drop  = mem_read | mem_write;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
               e_pop = exp_q.pop_front();
               check("rsp_addr", rsp_addr, e_pop.a);
               check("rsp_data", rsp_data, e_pop.d);
            end
         end
      end
      cyc++;
   end

   task automatic send(input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit want_rsp);
      int   n = 0;
      exp_t e;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      while (!cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("cmd_accept_bound", 0, 1);
      else if (we) ref_mem[a] = d;
      else if (want_rsp) begin
         e.a = a;
         e.d = ref_mem.exists(a) ? ref_mem[a] : '0;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_quiet(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || rsp_valid) && n < 2000);
      if (busy || rsp_valid) check(tag, 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      bit held_issue;
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_ctl", {rsp_valid, mem_read, mem_write, busy, timeout_err}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rsp_data", rsp_data, 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // single write
      send(1'b1, 20'h00012, 32'hDEADBEEF, 1'b0);
      wait_quiet("t1_quiet");
      check("t1_wr_width", last_req, 9);
      check("t1_no_rsp", last_rsp, 0);
      check("t1_sram", sram[20'h00012], 32'hDEADBEEF);

      // read back with consumer ready
      rsp_ready = 1'b1;
      send(1'b0, 20'h00012, '0, 1'b1);
      wait_quiet("t2_quiet");
      check("t2_rsp_width", last_rsp, 1);
      check("t2_rd_width", last_req, 8);

      // back-to-back writes: idle gap between requests
      send(1'b1, 20'h00020, 32'h11112222, 1'b0);
      send(1'b1, 20'h00021, 32'h33334444, 1'b0);
      wait_quiet("gap_quiet");
      check("gap_low", last_lo, 2);

      // five reads with consumer stalled
      rsp_ready = 1'b0;
      send(1'b0, 20'h00012, '0, 1'b1);
      send(1'b0, 20'h00020, '0, 1'b1);
      send(1'b0, 20'h00021, '0, 1'b1);
      send(1'b0, 20'h00030, '0, 1'b1);
      send(1'b0, 20'h00012, '0, 1'b1);
      check("fifo_full_ready", cmd_ready, 0);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("first_rsp_seen", rsp_valid, 1);
      held_issue = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (mem_read) held_issue = 1'b1;
      end
      check("hold_no_issue", held_issue, 0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_quiet("drain_quiet");
      check("drain_sb_empty", exp_q.size(), 0);

      // stale done still high when the next read is issued
      stale_cfg = 5;
      send(1'b0, 20'h00021, '0, 1'b1);
      wait_quiet("stale_quiet");
      stale_cfg = 0;
      check("stale_width", last_req, 13);

      // controller never completes: watchdog, then queued write proceeds
      hang = 1'b1;
      send(1'b0, 20'h00040, '0, 1'b0);
      send(1'b1, 20'h00041, 32'h5A5A5A5A, 1'b0);
      n = 0;
      while (!to_seen && n < 300) begin
         @(negedge clk);
         n++;
      end
      hang = 1'b0;
      wait_quiet("to_quiet");
      check("to_delay", to_delay, 64);
      check("to_drop", to_drop, 0);
      check("to_sticky", timeout_err, 1);
      check("to_next_write", sram[20'h00041], 32'h5A5A5A5A);
      check("to_no_rsp", exp_q.size(), 0);

      // reset in the middle of a read
      send(1'b0, 20'h00012, '0, 1'b1);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_ctl", {rsp_valid, mem_read, mem_write, busy, timeout_err}, 0);
      check("mid_rst_ready", cmd_ready, 1);
      check("mid_rst_addr", mem_addr, 0);
      exp_q.delete();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      send(1'b0, 20'h00021, '0, 1'b1);
      wait_quiet("post_rst_quiet");
      check("post_rst_sb_empty", exp_q.size(), 0);
      check("rw_exclusive", both_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_time_limit: got expired, want done");
      $fatal(1);
   end

endmodule

`default_nettype wire
